// File: rtl/ras_predictor.sv
// rtl/ras_predictor.sv - parametrised return address stack with checkpoint/restore FIFO
//
// Calls push their return address and returns pop the top entry. Each
// in-flight predicted branch can save a snapshot of the stack state; the
// oldest snapshot is released on correct resolution or restored on
// misprediction.
//
// Optional feature macro: RAS_COUNTER_EN
//   Adds a per-entry recursion counter. Repeated pushes of the address already
//   on top bump the counter instead of allocating a new entry. Pops then
//   decrement the counter before they pop the entry. Snapshots also save the
//   counter. When the macro is undefined, no counter storage exists and every
//   push allocates a new entry.
//
// Ports:
//   clk          clock
//   resetn       asynchronous active-low reset
//   stall        pipeline stall; blocks push, pop and ckpt_alloc
//   push_valid   call predicted this cycle; push_addr is its return address
//   push_addr    return address (pc+8)
//   pop_valid    return predicted this cycle
//   ckpt_alloc   snapshot stack state for a new predicted branch
//   ckpt_commit  oldest branch resolved correctly; drop oldest snapshot
//   recover      oldest branch mispredicted; restore oldest snapshot
//   top_valid    stack non-empty
//   top_addr     address at top of stack (0 when empty)
//   ckpt_full    checkpoint FIFO full
//   ckpt_empty   checkpoint FIFO empty

module ras_predictor #(
    parameter int DEPTH      = 8,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 6,
    parameter int CKPT_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              stall,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop_valid,
    input  logic              ckpt_alloc,
    input  logic              ckpt_commit,
    input  logic              recover,
    output logic              top_valid,
    output logic [ADDR_W-1:0] top_addr,
    output logic              ckpt_full,
    output logic              ckpt_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int CP_W  = (CKPT_DEPTH > 1) ? $clog2(CKPT_DEPTH) : 1;
    localparam int CC_W  = $clog2(CKPT_DEPTH + 1);

    // Stack state
    logic [PTR_W-1:0]  ptr, ptr_n;
    logic [OCC_W-1:0]  occ, occ_n;
    logic [ADDR_W-1:0] ent_addr [DEPTH];

    // Single write port into the entry array
    logic              we;
    logic [PTR_W-1:0]  wa;
    logic [ADDR_W-1:0] wd_addr;

    // Checkpoint FIFO
    logic [PTR_W-1:0]  ck_ptr  [CKPT_DEPTH];
    logic [OCC_W-1:0]  ck_occ  [CKPT_DEPTH];
    logic [ADDR_W-1:0] ck_addr [CKPT_DEPTH];
    logic [CP_W-1:0]   rd_ptr, wr_ptr;
    logic [CC_W-1:0]   f_cnt;
    logic              f_clear, do_alloc, do_commit;

`ifdef RAS_COUNTER_EN
    logic [CNT_W-1:0]  ent_cnt [DEPTH];
    logic [CNT_W-1:0]  ck_cnt  [CKPT_DEPTH];
    logic [CNT_W-1:0]  wd_cnt;
    logic [CNT_W-1:0]  top_cnt;
    assign top_cnt = ent_cnt[ptr];
`endif

    // The FIFO depth need not be a power-of-two-aligned pointer width, so wrap explicitly
    function automatic logic [CP_W-1:0] cp_inc(input logic [CP_W-1:0] p);
        if (p == CP_W'(CKPT_DEPTH - 1)) return '0;
        else                            return p + 1'b1;
    endfunction

    assign top_valid  = (occ != '0);
    assign top_addr   = top_valid ? ent_addr[ptr] : '0;
    assign ckpt_full  = (f_cnt == CC_W'(CKPT_DEPTH));
    assign ckpt_empty = (f_cnt == '0);

    always_comb begin
        ptr_n     = ptr;
        occ_n     = occ;
        we        = 1'b0;
        wa        = ptr;
        wd_addr   = push_addr;
`ifdef RAS_COUNTER_EN
        wd_cnt    = '0;
`endif
        f_clear   = 1'b0;
        do_alloc  = 1'b0;
        do_commit = 1'b0;

        if (recover) begin
            // Recovery overrides stall and every other request this cycle
            f_clear = 1'b1;
            if (!ckpt_empty) begin
                ptr_n   = ck_ptr[rd_ptr];
                occ_n   = ck_occ[rd_ptr];
                we      = 1'b1;
                wa      = ck_ptr[rd_ptr];
                wd_addr = ck_addr[rd_ptr];
`ifdef RAS_COUNTER_EN
                wd_cnt  = ck_cnt[rd_ptr];
`endif
            end
        end else begin
            // Branch resolution is independent of the fetch stall
            do_commit = ckpt_commit && !ckpt_empty;
            if (!stall) begin
                // A same-cycle commit frees the oldest slot before the alloc lands
                do_alloc = ckpt_alloc && (!ckpt_full || do_commit);
                if (push_valid && pop_valid && top_valid) begin
                    // Return followed by call: replace top in place
                    we = 1'b1;
                    wa = ptr;
                end else if (push_valid) begin
`ifdef RAS_COUNTER_EN
                    if (top_valid && push_addr == ent_addr[ptr] && !(&top_cnt)) begin
                        we      = 1'b1;
                        wa      = ptr;
                        wd_addr = ent_addr[ptr];
                        wd_cnt  = top_cnt + 1'b1;
                    end else
`endif
                    begin
                        // Circular: on overflow the oldest entry is overwritten
                        ptr_n = ptr + 1'b1;
                        wa    = ptr + 1'b1;
                        we    = 1'b1;
                        if (occ != OCC_W'(DEPTH)) occ_n = occ + 1'b1;
                    end
                end else if (pop_valid && top_valid) begin
`ifdef RAS_COUNTER_EN
                    if (top_cnt != '0) begin
                        we      = 1'b1;
                        wa      = ptr;
                        wd_addr = ent_addr[ptr];
                        wd_cnt  = top_cnt - 1'b1;
                    end else
`endif
                    begin
                        ptr_n = ptr - 1'b1;
                        occ_n = occ - 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr <= '0;
            occ <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
`ifdef RAS_COUNTER_EN
                ent_cnt[i]  <= '0;
`endif
            end
        end else begin
            ptr <= ptr_n;
            occ <= occ_n;
            if (we) begin
                ent_addr[wa] <= wd_addr;
`ifdef RAS_COUNTER_EN
                ent_cnt[wa]  <= wd_cnt;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            f_cnt  <= '0;
        end else if (f_clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            f_cnt  <= '0;
        end else begin
            if (do_alloc)  wr_ptr <= cp_inc(wr_ptr);
            if (do_commit) rd_ptr <= cp_inc(rd_ptr);
            case ({do_alloc, do_commit})
                2'b10:   f_cnt <= f_cnt + 1'b1;
                2'b01:   f_cnt <= f_cnt - 1'b1;
                default: f_cnt <= f_cnt;
            endcase
        end
    end

    // Snapshot payload is only read while the FIFO is non-empty, so it needs no reset.
    // It captures the state before this cycle's push/pop.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            ck_ptr[wr_ptr]  <= ptr;
            ck_occ[wr_ptr]  <= occ;
            ck_addr[wr_ptr] <= ent_addr[ptr];
`ifdef RAS_COUNTER_EN
            ck_cnt[wr_ptr]  <= top_cnt;
`endif
        end
    end

endmodule

// File: tb/tb_ras_predictor.sv
// tb/tb_ras_predictor.sv - directed scoreboard bench for ras_predictor

module tb_ras_predictor;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, push_valid, pop_valid, ckpt_alloc, ckpt_commit, recover;
    logic [31:0] push_addr;
    logic        top_valid, ckpt_full, ckpt_empty;
    logic [31:0] top_addr;

    always #5 clk = ~clk;

    ras_predictor #(.DEPTH(8), .ADDR_W(32), .CNT_W(6), .CKPT_DEPTH(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stall       (stall),
        .push_valid  (push_valid),
        .push_addr   (push_addr),
        .pop_valid   (pop_valid),
        .ckpt_alloc  (ckpt_alloc),
        .ckpt_commit (ckpt_commit),
        .recover     (recover),
        .top_valid   (top_valid),
        .top_addr    (top_addr),
        .ckpt_full   (ckpt_full),
        .ckpt_empty  (ckpt_empty)
    );

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] a;
        logic        f;
        logic        e;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    task automatic cmp(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] a,
                              input logic f, input logic e);
        exp_t x;
        x.tag = tag; x.v = v; x.a = a; x.f = f; x.e = e;
        q.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            cmp(x.tag, "top_valid",  {31'd0, top_valid},  {31'd0, x.v});
            cmp(x.tag, "top_addr",   top_addr,            x.a);
            cmp(x.tag, "ckpt_full",  {31'd0, ckpt_full},  {31'd0, x.f});
            cmp(x.tag, "ckpt_empty", {31'd0, ckpt_empty}, {31'd0, x.e});
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic step(input logic pu, input logic [31:0] pa, input logic po,
                        input logic al, input logic cm, input logic rc, input logic st);
        push_valid  = pu;
        push_addr   = pa;
        pop_valid   = po;
        ckpt_alloc  = al;
        ckpt_commit = cm;
        recover     = rc;
        stall       = st;
        @(posedge clk);
        #1;
        push_valid  = 1'b0;
        push_addr   = 32'd0;
        pop_valid   = 1'b0;
        ckpt_alloc  = 1'b0;
        ckpt_commit = 1'b0;
        recover     = 1'b0;
        stall       = 1'b0;
    endtask

    task automatic push(input logic [31:0] a); step(1, a, 0, 0, 0, 0, 0); endtask
    task automatic pop();                      step(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic alloc();                    step(0, 0, 0, 1, 0, 0, 0); endtask
    task automatic commit();                   step(0, 0, 0, 0, 1, 0, 0); endtask

    initial begin
        resetn = 1'b0;
        stall = 0; push_valid = 0; pop_valid = 0; push_addr = 0;
        ckpt_alloc = 0; ckpt_commit = 0; recover = 0;
        #12;
        expect_out("reset", 0, 32'h0, 0, 1); check_out();
        resetn = 1'b1;

        // Basic push/pop
        push(32'h100); push(32'h200); push(32'h300);
        expect_out("push3", 1, 32'h300, 0, 1); check_out();
        pop(); expect_out("pop1", 1, 32'h200, 0, 1); check_out();
        pop(); expect_out("pop2", 1, 32'h100, 0, 1); check_out();
        pop(); expect_out("pop3", 0, 32'h0, 0, 1); check_out();
        pop(); expect_out("pop_empty", 0, 32'h0, 0, 1); check_out();

        // Overflow: 9 pushes into 8 entries, oldest lost
        for (int i = 1; i <= 9; i++) push(32'h10 * i);
        expect_out("ovf_top", 1, 32'h90, 0, 1); check_out();
        for (int k = 1; k <= 7; k++) begin
            pop();
            expect_out($sformatf("ovf_pop%0d", k), 1, 32'h90 - 32'h10 * k, 0, 1); check_out();
        end
        pop(); expect_out("ovf_pop8", 0, 32'h0, 0, 1); check_out();

        // Checkpoint and recover, including restore of an overwritten top entry
        push(32'hA0);
        alloc(); expect_out("ck_alloc", 1, 32'hA0, 0, 0); check_out();
        push(32'hB0); push(32'hC0); pop();
        expect_out("ck_spec", 1, 32'hB0, 0, 0); check_out();
        pop();
        step(1, 32'hD0, 1, 0, 0, 0, 0);
        expect_out("ck_overwrite", 1, 32'hD0, 0, 0); check_out();
        step(0, 0, 0, 0, 0, 1, 0);
        expect_out("ck_recover", 1, 32'hA0, 0, 1); check_out();
        pop(); expect_out("ck_occ1", 0, 32'h0, 0, 1); check_out();

        // Snapshot takes state before a same-cycle push
        step(1, 32'hE0, 0, 1, 0, 0, 0);
        push(32'hF0);
        expect_out("pre_push", 1, 32'hF0, 0, 0); check_out();
        step(0, 0, 0, 0, 0, 1, 0);
        expect_out("pre_push_rec", 0, 32'h0, 0, 1); check_out();

        // FIFO fill, drop on full, commit+alloc, drain
        alloc(); alloc(); alloc();
        expect_out("fifo3", 0, 32'h0, 0, 0); check_out();
        alloc(); expect_out("fifo4", 0, 32'h0, 1, 0); check_out();
        alloc(); expect_out("fifo_drop", 0, 32'h0, 1, 0); check_out();
        step(0, 0, 0, 1, 1, 0, 0);
        expect_out("fifo_cm_al", 0, 32'h0, 1, 0); check_out();
        commit(); commit(); commit();
        expect_out("fifo_drain3", 0, 32'h0, 0, 0); check_out();
        commit(); expect_out("fifo_drain4", 0, 32'h0, 0, 1); check_out();
        commit(); alloc();
        expect_out("fifo_cm_empty", 0, 32'h0, 0, 0); check_out();
        commit(); expect_out("fifo_back_empty", 0, 32'h0, 0, 1); check_out();

        // Stall blocks stack/alloc but not commit
        push(32'h500); alloc();
        step(1, 32'h600, 0, 0, 1, 0, 1);
        expect_out("stall_commit", 1, 32'h500, 0, 1); check_out();
        step(0, 0, 1, 1, 0, 0, 1);
        expect_out("stall_alloc", 1, 32'h500, 0, 1); check_out();
        alloc(); push(32'h700);
        step(1, 32'h800, 0, 0, 0, 1, 1);
        expect_out("rec_stall", 1, 32'h500, 0, 1); check_out();
        push(32'h900);
        step(0, 0, 0, 0, 0, 1, 0);
        expect_out("rec_empty_fifo", 1, 32'h900, 0, 1); check_out();

        // Asynchronous reset between clock edges
        alloc();
        #2;
        resetn = 1'b0;
        #1;
        expect_out("async_reset", 0, 32'h0, 0, 1); check_out();
        resetn = 1'b1;

`ifdef RAS_COUNTER_EN
        push(32'h400); push(32'h400); push(32'h400);
        expect_out("cnt_push", 1, 32'h400, 0, 1); check_out();
        pop(); pop();
        expect_out("cnt_pop2", 1, 32'h400, 0, 1); check_out();
        pop(); expect_out("cnt_pop3", 0, 32'h0, 0, 1); check_out();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
